// File: rtl/serial_rx.sv
// UART-style frame receiver: 8N1, mid-bit sampling, one-cycle data/error strobes.
// Strobe one cycle after the stop sample; no backpressure, data_out_o is overwritten by the next good frame.
module serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic       sysclk_i,
   input  logic       reset_n_i,
   input  logic       rx_in_i,
   output logic [7:0] data_out_o,
   output logic       data_valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] H_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] N_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          sync1_q, rx_s_q;

   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx_in_i;
         rx_s_q  <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // Half a bit in: a line back high means the falling edge was a glitch.
            if (cnt_q == H_LAST) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == N_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == N_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Hold off until the line recovers so a stuck-low line reports once.
            cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out_o   = data_q;
   assign data_valid_o = valid_q;
   assign frame_err_o  = ferr_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx at 16 clocks/bit: directed scenarios plus random frames,
// strobes scored against expected events predicted from the line waveform.
module tb_serial_rx;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   localparam int LAT = 2 + H + 9 * CPB + 1;

   typedef struct {
      int         cyc;
      logic       ferr;
      logic [7:0] data;
   } ev_t;

   logic       sysclk;
   logic       reset_n;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int         cyc;
   int         n_vec;
   int         n_err;
   ev_t        exp_q[$];
   ev_t        mon_ev;
   logic [7:0] last_good;

   serial_rx #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk_i    (sysclk),
      .reset_n_i   (reset_n),
      .rx_in_i     (rx),
      .data_out_o  (data_out),
      .data_valid_o(data_valid),
      .frame_err_o (frame_err),
      .busy_o      (busy)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Line level during bit slot j of a frame (0 start, 1..8 data, 9 stop, later = what follows).
   function automatic logic slot_val(input logic [7:0] b, input logic stop_v, input logic after_v, input int j);
      logic [7:0] bb;
      bb = b;
      if (j == 0) return 1'b0;
      if (j <= 8) return bb[j-1];
      if (j == 9) return stop_v;
      return after_v;
   endfunction

   // Receiver samples land H + k*CPB cycles into the frame; with bit period p that falls in slot (H+k*CPB)/p.
   function automatic logic [8:0] model_frame(input logic [7:0] b, input int p, input logic stop_v, input logic after_v);
      logic [7:0] d;
      logic       ok;
      d = 8'h00;
      for (int i = 0; i < 8; i++) d[i] = slot_val(b, stop_v, after_v, (H + (i + 1) * CPB) / p);
      ok = slot_val(b, stop_v, after_v, (H + 9 * CPB) / p);
      return {ok, d};
   endfunction

   // Called at posedge+1; drives up to max_cyc cycles of one frame and queues the predicted strobe.
   task automatic send(input logic [7:0] b, input int p, input logic stop_v, input logic after_v, input int max_cyc);
      logic [8:0] m;
      ev_t        e;
      int         t0;
      t0 = cyc;
      if (max_cyc >= 10 * p) begin
         m      = model_frame(b, p, stop_v, after_v);
         e.cyc  = t0 + LAT;
         e.ferr = ~m[8];
         e.data = m[7:0];
         exp_q.push_back(e);
      end
      for (int t = 0; t < 10 * p && t < max_cyc; t++) begin
         rx = slot_val(b, stop_v, after_v, t / p);
         tick();
      end
   endtask

   always @(negedge sysclk) begin
      if (reset_n) begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check_val("missed_strobe", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (data_valid || frame_err) begin
            check_val("dual_strobe", 32'(data_valid & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
               check_val("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               mon_ev = exp_q.pop_front();
               check_val("strobe_cycle", cyc, mon_ev.cyc);
               check_val("strobe_kind_ferr", 32'(frame_err), 32'(mon_ev.ferr));
               if (mon_ev.ferr) begin
                  check_val("data_hold", 32'(data_out), 32'(last_good));
               end else begin
                  check_val("rx_data", 32'(data_out), 32'(mon_ev.data));
                  last_good = mon_ev.data;
               end
            end
         end
      end
   end

   initial begin
      int         t0;
      int         gap;
      logic [7:0] b;
      n_vec     = 0;
      n_err     = 0;
      last_good = 8'h00;
      rx        = 1'b1;
      reset_n   = 1'b0;

      repeat (5) tick();
      check_val("rst_data_out", 32'(data_out), 32'h00);
      check_val("rst_valid", 32'(data_valid), 32'd0);
      check_val("rst_ferr", 32'(frame_err), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         check_val("idle_busy", 32'(busy), 32'd0);
      end

      // 4-cycle glitch: start sample at t0+11 sees the line high again
      t0 = cyc;
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      tick();
      check_val("glitch_busy_rise", 32'(busy), 32'd1);
      while (cyc < t0 + 10) tick();
      check_val("glitch_busy_hold", 32'(busy), 32'd1);
      tick();
      check_val("glitch_busy_fall", 32'(busy), 32'd0);
      repeat (20) tick();

      // 0x81 with low stop bit, line held low 50 more cycles
      t0 = cyc;
      send(8'h81, CPB, 1'b0, 1'b0, 10 * CPB);
      rx = 1'b0;
      repeat (50) tick();
      check_val("break_busy", 32'(busy), 32'd1);
      check_val("ferr_data_out", 32'(data_out), 32'h00);
      rx = 1'b1;
      while (cyc < t0 + 212) tick();
      check_val("break_busy_hold", 32'(busy), 32'd1);
      tick();
      check_val("break_busy_fall", 32'(busy), 32'd0);
      repeat (10) tick();

      send(8'hA5, CPB, 1'b1, 1'b1, 10 * CPB);
      repeat (20) tick();

      send(8'h00, CPB, 1'b1, 1'b1, 10 * CPB);
      send(8'hFF, CPB, 1'b1, 1'b1, 10 * CPB);
      send(8'h3C, CPB, 1'b1, 1'b1, 10 * CPB);
      repeat (20) tick();

      // abort 0x5A partway through data bit 4
      send(8'h5A, CPB, 1'b1, 1'b1, 5 * CPB + H);
      check_val("pre_reset_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      rx      = 1'b1;
      exp_q.delete();
      last_good = 8'h00;
      #1;
      check_val("async_rst_busy", 32'(busy), 32'd0);
      check_val("async_rst_data", 32'(data_out), 32'h00);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      send(8'h77, CPB, 1'b1, 1'b1, 10 * CPB);
      repeat (20) tick();

      send(8'hC3, 15, 1'b1, 1'b1, 150);
      repeat (40) tick();
      send(8'hC3, 17, 1'b1, 1'b1, 170);
      repeat (40) tick();

      for (int i = 0; i < 20; i++) begin
         b   = 8'($urandom_range(0, 255));
         gap = int'($urandom_range(0, 12));
         send(b, CPB, 1'b1, 1'b1, 10 * CPB);
         repeat (gap) tick();
      end

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      repeat (5) tick();
      check_val("queue_drained", exp_q.size(), 32'd0);
      check_val("final_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
